// File: rtl/alu_seq_nbit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus iterative unsigned
// shift-add multiply and restoring divide behind a Start/Busy/Done handshake.
module alu_seq_nbit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       alu_op_i,
    input  logic             b_negate_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             carry_out_o,
    output logic             div_zero_o
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_SLT  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MULU = 3'b101;
    localparam logic [2:0] OP_DIVU = 3'b110;
    localparam logic [2:0] OP_NOR  = 3'b111;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // opnd_q holds the multiplicand or divisor; hi_q/lo_q form the shared
    // 2*WIDTH work register (partial product / remainder:quotient).
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             ovf_q, ovf_d;
    logic             carry_q, carry_d;
    logic             divz_q, divz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   addsub;
    logic             addsub_ovf;
    logic [WIDTH:0]   sub_full;
    logic             sub_ovf;
    logic             slt_bit;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] div_rem_nx, div_quo_nx;
    logic             last_iter;

    assign b_eff      = b_negate_i ? ~b_i : b_i;
    assign addsub     = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, b_negate_i};
    assign addsub_ovf = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (addsub[WIDTH-1] != a_i[WIDTH-1]);

    // SLT always compares via A-B regardless of BNegate.
    assign sub_full = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
    assign sub_ovf  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sub_full[WIDTH-1] != a_i[WIDTH-1]);
    assign slt_bit  = sub_full[WIDTH-1] ^ sub_ovf;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Remainder stays below the divisor, so a set bit WIDTH means "restore".
    assign div_shift  = {hi_q, lo_q[WIDTH-1]};
    assign div_diff   = div_shift - {1'b0, opnd_q};
    assign div_rem_nx = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    assign div_quo_nx = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opnd_d      = opnd_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        ovf_d       = ovf_q;
        carry_d     = carry_q;
        divz_d      = divz_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    done_d      = 1'b1;
                    result_hi_d = '0;
                    ovf_d       = 1'b0;
                    carry_d     = 1'b0;
                    divz_d      = 1'b0;
                    unique case (alu_op_i)
                        OP_AND: result_d = a_i & b_i;
                        OP_SLT: result_d = {{(WIDTH-1){1'b0}}, slt_bit};
                        OP_OR:  result_d = a_i | b_i;
                        OP_XOR: result_d = a_i ^ b_i;
                        OP_NOR: result_d = ~(a_i | b_i);
                        OP_ADD: begin
                            result_d = addsub[WIDTH-1:0];
                            ovf_d    = addsub_ovf;
                            carry_d  = addsub[WIDTH];
                        end
                        OP_MULU: begin
                            done_d      = 1'b0;
                            result_d    = result_q;
                            result_hi_d = result_hi_q;
                            ovf_d       = ovf_q;
                            carry_d     = carry_q;
                            divz_d      = divz_q;
                            state_d     = S_MUL;
                            cnt_d       = '0;
                            opnd_d      = a_i;
                            hi_d        = '0;
                            lo_d        = b_i;
                        end
                        OP_DIVU: begin
                            if (b_i == '0) begin
                                result_d    = '1;
                                result_hi_d = a_i;
                                divz_d      = 1'b1;
                            end else begin
                                done_d      = 1'b0;
                                result_d    = result_q;
                                result_hi_d = result_hi_q;
                                ovf_d       = ovf_q;
                                carry_d     = carry_q;
                                divz_d      = divz_q;
                                state_d     = S_DIV;
                                cnt_d       = '0;
                                opnd_d      = b_i;
                                hi_d        = '0;
                                lo_d        = a_i;
                            end
                        end
                        default: result_d = result_q;
                    endcase
                end
            end
            S_MUL: begin
                hi_d  = mul_hi_nx;
                lo_d  = mul_lo_nx;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    result_d    = mul_lo_nx;
                    result_hi_d = mul_hi_nx;
                    ovf_d       = (mul_hi_nx != '0);
                    carry_d     = 1'b0;
                    divz_d      = 1'b0;
                end
            end
            S_DIV: begin
                hi_d  = div_rem_nx;
                lo_d  = div_quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    result_d    = div_quo_nx;
                    result_hi_d = div_rem_nx;
                    ovf_d       = 1'b0;
                    carry_d     = 1'b0;
                    divz_d      = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
            divz_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            ovf_q       <= ovf_d;
            carry_q     <= carry_d;
            divz_q      <= divz_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        opnd_q <= opnd_d;
        hi_q   <= hi_d;
        lo_q   <= lo_d;
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign result_hi_o = result_hi_q;
    assign zero_o      = (result_q == '0);
    assign overflow_o  = ovf_q;
    assign carry_out_o = carry_q;
    assign div_zero_o  = divz_q;

endmodule

// File: doc/alu_seq_nbit.md
Name: alu_seq_nbit

Overview:
- Parametrised successor to the team's 16-bit ripple ALU. It keeps the same AND/SLT/OR/XOR/ADD/SUB operation set.
- Adds an iterative unsigned multiplier, an iterative unsigned divider, a NOR operation, registered outputs and a Start/Busy/Done handshake.
- Sits in the execute stage of the multi-cycle CPU. The control FSM stalls on Busy and samples results on Done.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- CNT_W, 5, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; accepted only when Busy=0.
- A  input  WIDTH  operand A (dividend for DIVU).
- B  input  WIDTH  operand B (divisor for DIVU).
- ALUOp  input  3  000 AND, 001 SLT, 010 OR, 011 XOR, 100 ADD/SUB, 101 MULU, 110 DIVU, 111 NOR.
- BNegate  input  1  for ALUOp=100: 0 ADD, 1 SUB (A+~B+1); for 001 must be 1; ignored otherwise.
- Busy  output  1  multi-cycle operation in progress.
- Done  output  1  one-cycle pulse: Result/ResultHi/flags valid.
- Result  output  WIDTH  primary result (product low half, quotient).
- ResultHi  output  WIDTH  product high half or remainder; 0 for single-cycle ops.
- Zero  output  1  Result == 0.
- Overflow  output  1  signed overflow for ADD/SUB; ResultHi != 0 for MULU; 0 otherwise.
- CarryOut  output  1  carry out of the MSB for ADD/SUB; 0 otherwise.
- DivZero  output  1  DIVU with B == 0.

Behaviour:
- Reset: state IDLE; Busy=0, Done=0, DivZero=0, Result=0, ResultHi=0, Overflow=0, CarryOut=0. Zero=1 because it is derived from Result.
- Reset asserted mid-operation aborts the operation. The next cycle shows the reset values, and no Done is issued for the aborted operation.
- States: IDLE, MUL, DIV.
- Start is accepted in IDLE, which includes the Done cycle, so back-to-back issue is allowed. While Busy=1, Start is ignored and A/B/ALUOp/BNegate may change freely.
- Operands are captured internally on acceptance. Outputs keep their previous values until the next Done.

Single-cycle ops (000-100, 111):
- Start at edge t → outputs registered at t; Done=1 during cycle t+1; Busy stays 0.
- SLT: Result = {0…0, S}, where S = sign(A−B) XOR signed-overflow(A−B). Zero and flags are computed from this Result; Overflow=0 and CarryOut=0.
- ADD/SUB: WIDTH-bit wrap-around. CarryOut = bit WIDTH of A + (B or ~B) + BNegate. Overflow = carry into MSB XOR carry out of MSB.

MULU (shift-add):
- Acceptance at t → state MUL, Busy=1 for cycles t+1 … t+WIDTH. One multiplier bit is processed per cycle, and the counter counts 0 … WIDTH−1.
- After the last iteration: {ResultHi, Result} = A*B (2·WIDTH bits, exact), Busy=0, state IDLE, Done=1 in cycle t+WIDTH+1.

DIVU (restoring):
- Same timing as MULU: WIDTH iterations, Done in cycle t+WIDTH+1. Result = A/B, ResultHi = A mod B, DivZero=0.
- B==0: no iteration. Behaves as a single-cycle op: Done in cycle t+1, Result = all ones, ResultHi = A, DivZero=1, Overflow=0.

Flags and pulses:
- DivZero and Overflow/CarryOut update only on Done and hold otherwise. DivZero clears on the next accepted non-faulting operation.
- Done is never high for two consecutive cycles unless consecutive operations were accepted.
- Start and Reset in the same cycle: Reset wins and the request is dropped.

Test Plan:
- Reset; WIDTH=16; Start ADD A=16'h7FFF B=16'h0001 BNegate=0 → Done next cycle; Result=16'h8000, Overflow=1, CarryOut=0, Zero=0.
- SUB A=16'h0005 B=16'h0005 BNegate=1 → Result=0, Zero=1, CarryOut=1. Then SLT A=16'hFFFF (−1) B=16'h0001 → Result=16'h0001.
- MULU A=16'hFFFF B=16'hFFFF:
  - Busy high exactly 16 cycles, Done in cycle 17.
  - {ResultHi, Result}=32'hFFFE0001, Overflow=1.
  - Start pulsed mid-operation is ignored, with no change in result or latency.
- DIVU A=16'd1000 B=16'd7 → Done at cycle 17; Result=16'd142, ResultHi=16'd6, DivZero=0. Then DIVU B=0 A=16'h1234 → Done at cycle 1; Result=16'hFFFF, ResultHi=16'h1234, DivZero=1.
- Back-to-back: Start XOR A=16'hF0F0 B=16'hFF00 issued in MULU's Done cycle → next cycle Done again, Result=16'h0FF0, ResultHi=0.
- Reset asserted at cycle 8 of a DIVU → no Done; all outputs at reset values next cycle; a new ADD 3+4 afterwards gives Result=7.
